timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl -- control FSM for a minute-preset countdown kitchen timer.
//
// Sequences a BCD countdown datapath.
//   - IDLE  : waits for a start press. The press latches the minute preset,
//             clamped to 9, and pulses LOAD.
//   - RUN   : forwards the 1 Hz TICK as CNT_EN until the digits read 0:00.
//   - PAUSE : optional state that freezes the countdown.
//   - ALARM : drives a square wave on BZ until a stop press arrives or
//             ALARM_TICKS ticks have elapsed.
//
// Configuration macro: TIMER_PAUSE_EN
//   When defined, PSW[2] (pause/resume) and the PAUSE state are enabled.
//   When undefined, PAUSE is unreachable and PSW[2] is ignored.
//
// Parameters:
//   ALARM_TICKS  TICK pulses the alarm sounds before auto-stop (1..255)
//   BZ_HALF      CLOCK cycles per buzzer half-period (1..255)
//
// Ports:
//   CLOCK                   in   single clock, rising edge
//   RESET                   in   synchronous active-high reset
//   PSW[3:0]                in   buttons, 1 = pressed: [0] start, [1] stop, [2] pause
//   RSW[3:0]                in   BCD minute preset
//   TICK                    in   one-cycle 1 Hz pulse
//   OUT_M/OUT_10S/OUT_1S    in   current countdown digits
//   CNT_EN                  out  count-down enable (combinational)
//   LOAD                    out  one-cycle datapath load pulse
//   LOAD_M[3:0]             out  latched minute preset
//   BZ                      out  speaker drive
//   LED[7:0]                out  [3:0] one-hot state, [7:4] LOAD_M
// -----------------------------------------------------------------------------
module timer_ctrl #(
    parameter int unsigned ALARM_TICKS = 30,
    parameter int unsigned BZ_HALF     = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] PSW,
    input  logic [3:0] RSW,
    input  logic       TICK,
    input  logic [3:0] OUT_M,
    input  logic [3:0] OUT_10S,
    input  logic [3:0] OUT_1S,
    output logic       CNT_EN,
    output logic       LOAD,
    output logic [3:0] LOAD_M,
    output logic       BZ,
    output logic [7:0] LED
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(ALARM_TICKS - 1);
    localparam logic [7:0] BZ_LAST   = 8'(BZ_HALF - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] psw_q_r;
    logic [3:0] press_s;
    logic       stop_s;
    logic       start_s;
    logic       pause_s;
    logic       zero_s;
    logic       load_nxt_s;
    logic       alarm_clr_s;
    logic       alarm_stay_s;
    logic [7:0] tick_cnt_r;
    logic [7:0] bz_cnt_r;
    logic       bz_r;
    logic       load_r;
    logic [3:0] load_m_r;
    logic [3:0] led_r;
    logic       unused_s;

    // One-hot LED encoding of a state.
    function automatic logic [3:0] state_onehot(input state_t s);
        logic [3:0] v;
        case (s)
            IDLE:    v = 4'b0001;
            RUN:     v = 4'b0010;
            PAUSE:   v = 4'b0100;
            ALARM:   v = 4'b1000;
            default: v = 4'b0001;
        endcase
        return v;
    endfunction

    // Clamp a BCD preset to the largest single-digit minute value.
    function automatic logic [3:0] clamp_min(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    // Rising-edge button detection.
    // Presses are resolved with priority stop > start > pause.
    assign press_s = PSW & ~psw_q_r;
    assign stop_s  = press_s[1];
    assign start_s = press_s[0] & ~press_s[1];
`ifdef TIMER_PAUSE_EN
    assign pause_s = press_s[2] & ~press_s[1] & ~press_s[0];
`else
    assign pause_s = 1'b0;
`endif
    assign unused_s = &{1'b0, press_s[3], press_s[2]};

    assign zero_s = (OUT_M == 4'd0) && (OUT_10S == 4'd0) && (OUT_1S == 4'd0);

    // The countdown enable follows TICK only while running and not yet at 0:00.
    assign CNT_EN = (state_r == RUN) && TICK && !zero_s;

    // Next-state logic and the events that load the datapath or arm the alarm.
    always_comb begin
        state_nxt_s  = state_r;
        load_nxt_s   = 1'b0;
        alarm_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // A start press with a zero preset is ignored.
                if (start_s && (RSW != 4'd0)) begin
                    state_nxt_s = RUN;
                    load_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (stop_s) begin
                    state_nxt_s = IDLE;
                end else if (zero_s) begin
                    state_nxt_s = ALARM;
                    alarm_clr_s = 1'b1;
                end else if (pause_s) begin
                    state_nxt_s = PAUSE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PAUSE: begin
`ifdef TIMER_PAUSE_EN
                if (stop_s) begin
                    state_nxt_s = IDLE;
                end else if (start_s || pause_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSE;
                end
`else
                // This state cannot be reached in this build; recover to IDLE.
                state_nxt_s = IDLE;
`endif
            end
            ALARM: begin
                if (stop_s || (TICK && (tick_cnt_r == TICK_LAST))) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ALARM;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign alarm_stay_s = (state_r == ALARM) && (state_nxt_s == ALARM);

    // State register, button history, LOAD pulse, preset latch and LED.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r  <= IDLE;
            psw_q_r  <= 4'hF;       // buttons held through reset give no press
            load_r   <= 1'b0;
            load_m_r <= 4'd0;
            led_r    <= 4'b0001;
        end else begin
            state_r <= state_nxt_s;
            psw_q_r <= PSW;
            load_r  <= load_nxt_s;
            if (load_nxt_s) begin
                load_m_r <= clamp_min(RSW);
            end else begin
                load_m_r <= load_m_r;
            end
            led_r <= state_onehot(state_nxt_s);
        end
    end

    // Alarm tick counter and buzzer divider.
    // Both are cleared on alarm entry, so the first BZ rise comes BZ_HALF clocks in.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tick_cnt_r <= 8'd0;
            bz_cnt_r   <= 8'd0;
            bz_r       <= 1'b0;
        end else if (alarm_clr_s || !alarm_stay_s) begin
            tick_cnt_r <= 8'd0;
            bz_cnt_r   <= 8'd0;
            bz_r       <= 1'b0;
        end else begin
            if (TICK) begin
                tick_cnt_r <= tick_cnt_r + 8'd1;
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
            if (bz_cnt_r == BZ_LAST) begin
                bz_cnt_r <= 8'd0;
                bz_r     <= ~bz_r;
            end else begin
                bz_cnt_r <= bz_cnt_r + 8'd1;
                bz_r     <= bz_r;
            end
        end
    end

    assign LOAD   = load_r;
    assign LOAD_M = load_m_r;
    assign BZ     = bz_r;
    assign LED    = {load_m_r, led_r};

endmodule

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl -- self-checking bench for timer_ctrl (default parameters).
//
// Expectations for registered outputs are queued before each clock edge and
// compared just after that edge. CNT_EN is checked mid-cycle against the
// inputs currently applied. The PAUSE scenario adapts to TIMER_PAUSE_EN.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;

    logic       CLOCK;
    logic       RESET;
    logic [3:0] PSW;
    logic [3:0] RSW;
    logic       TICK;
    logic [3:0] OUT_M;
    logic [3:0] OUT_10S;
    logic [3:0] OUT_1S;
    logic       CNT_EN;
    logic       LOAD;
    logic [3:0] LOAD_M;
    logic       BZ;
    logic [7:0] LED;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        string      tag;
        int         sel;      // 0 LOAD, 1 LOAD_M, 2 BZ, 3 LED
        logic [7:0] exp;
    } exp_t;

    exp_t sbq[$];

    timer_ctrl #(.ALARM_TICKS(30), .BZ_HALF(2)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .PSW    (PSW),
        .RSW    (RSW),
        .TICK   (TICK),
        .OUT_M  (OUT_M),
        .OUT_10S(OUT_10S),
        .OUT_1S (OUT_1S),
        .CNT_EN (CNT_EN),
        .LOAD   (LOAD),
        .LOAD_M (LOAD_M),
        .BZ     (BZ),
        .LED    (LED)
    );

    // Free-running clock.
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            0:       return {7'd0, LOAD};
            1:       return {4'd0, LOAD_M};
            2:       return {7'd0, BZ};
            default: return LED;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    // Queue LED, LOAD and BZ expectations for the next edge.
    task automatic exp_out(input string tag, input logic [7:0] led, input logic load, input logic bz);
        push({tag, ".led"}, 3, led);
        push({tag, ".load"}, 0, {7'd0, load});
        push({tag, ".bz"}, 2, {7'd0, bz});
    endtask

    // Drain the scoreboard just after each rising edge.
    always @(posedge CLOCK) begin
        exp_t e;
        #1;
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            check_val(e.tag, obs(e.sel), e.exp);
        end
    end

    task automatic clk_step();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic cnt_chk(input string tag, input logic exp);
        #1;
        check_val(tag, {7'd0, CNT_EN}, {7'd0, exp});
    endtask

    initial begin
        RESET = 1'b1; PSW = 4'h0; RSW = 4'd0; TICK = 1'b0;
        OUT_M = 4'd1; OUT_10S = 4'd0; OUT_1S = 4'd0;

        // Reset state, with start held through reset.
        exp_out("rst", 8'h01, 1'b0, 1'b0);
        push("rst.load_m", 1, 8'h00);
        clk_step();
        PSW = 4'h1; RSW = 4'd3;
        exp_out("rst_hold", 8'h01, 1'b0, 1'b0);
        clk_step();
        RESET = 1'b0;
        exp_out("held_start", 8'h01, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        clk_step();

        // Start with RSW=3.
        PSW = 4'h1; OUT_M = 4'd3;
        exp_out("start3", 8'h32, 1'b1, 1'b0);
        push("start3.load_m", 1, 8'h03);
        clk_step();
        exp_out("start3_hold", 8'h32, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        cnt_chk("run_notick", 1'b0);
        TICK = 1'b1;
        cnt_chk("run_tick", 1'b1);
        exp_out("run_stay", 8'h32, 1'b0, 1'b0);
        clk_step();
        TICK = 1'b0;

        // Pause press.
        PSW = 4'h4;
`ifdef TIMER_PAUSE_EN
        exp_out("pause", 8'h34, 1'b0, 1'b0);
`else
        exp_out("pause_off", 8'h32, 1'b0, 1'b0);
`endif
        clk_step();
        PSW = 4'h0; TICK = 1'b1;
`ifdef TIMER_PAUSE_EN
        cnt_chk("pause_tick", 1'b0);
`else
        cnt_chk("pause_off_tick", 1'b1);
`endif
        clk_step();
        TICK = 1'b0; PSW = 4'h1;
        exp_out("resume", 8'h32, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        clk_step();

        // Zero detection.
        OUT_M = 4'd0; OUT_10S = 4'd0; OUT_1S = 4'd1; TICK = 1'b1;
        cnt_chk("one_sec_left", 1'b1);
        OUT_1S = 4'd0;
        cnt_chk("zero_tick", 1'b0);
        exp_out("alarm_entry", 8'h38, 1'b0, 1'b0);
        clk_step();
        TICK = 1'b0;

        // Buzzer waveform: BZ_HALF=2 gives 0,1,1,0,0,1.
        for (int k = 1; k <= 6; k++) begin
            push("bz_wave", 2, {7'd0, 1'(((k / 2) % 2))});
            push("alarm_cnt_en", 3, 8'h38);
            clk_step();
        end

        // Auto-stop after the 30th tick.
        for (int i = 1; i <= 29; i++) begin
            TICK = 1'b1;
            push("alarm_hold", 3, 8'h38);
            if (i == 1) begin
                cnt_chk("alarm_cnt_en", 1'b0);
            end
            clk_step();
            TICK = 1'b0;
            clk_step();
        end
        TICK = 1'b1;
        exp_out("auto_idle", 8'h31, 1'b0, 1'b0);
        clk_step();
        cnt_chk("idle_tick", 1'b0);
        TICK = 1'b0;

        // RSW=12 clamps to 9; zero digits go straight into alarm.
        RSW = 4'd12; PSW = 4'h1;
        exp_out("start12", 8'h92, 1'b1, 1'b0);
        push("start12.load_m", 1, 8'h09);
        clk_step();
        PSW = 4'h0;
        exp_out("alarm2", 8'h98, 1'b0, 1'b0);
        clk_step();
        for (int i = 1; i <= 29; i++) begin
            TICK = 1'b1;
            clk_step();
            TICK = 1'b0;
            clk_step();
        end
        TICK = 1'b1; PSW = 4'h2;
        exp_out("stop_last_tick", 8'h91, 1'b0, 1'b0);
        clk_step();
        TICK = 1'b0;
        exp_out("stop_held", 8'h91, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        clk_step();

        // Stop takes priority over zero detection in RUN.
        RSW = 4'd5; PSW = 4'h1; OUT_M = 4'd5;
        exp_out("start5", 8'h52, 1'b1, 1'b0);
        clk_step();
        PSW = 4'h2; OUT_M = 4'd0;
        exp_out("stop_vs_zero", 8'h51, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        clk_step();

        // A zero preset is ignored.
        RSW = 4'd0; PSW = 4'h1;
        exp_out("start0", 8'h51, 1'b0, 1'b0);
        clk_step();
        PSW = 4'h0;
        clk_step();

        // Reset mid-alarm with start held.
        RSW = 4'd2; PSW = 4'h1;
        exp_out("start2", 8'h22, 1'b1, 1'b0);
        clk_step();
        PSW = 4'h0;
        exp_out("alarm3", 8'h28, 1'b0, 1'b0);
        clk_step();
        clk_step();
        push("bz_before_rst", 2, 8'h01);
        clk_step();
        PSW = 4'h1; RESET = 1'b1;
        exp_out("rst_alarm", 8'h01, 1'b0, 1'b0);
        push("rst_alarm.load_m", 1, 8'h00);
        clk_step();
        RESET = 1'b0;
        exp_out("post_rst_held", 8'h01, 1'b0, 1'b0);
        clk_step();
        exp_out("post_rst_held2", 8'h01, 1'b0, 1'b0);
        clk_step();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
